sram_mem_arbiter: RTL and testbench

- Sits directly downstream of the CPU's instruction and data SRAM-like ports.
- Arbitrates the two ports onto one single-outstanding memory bus, with data having priority over instruction.
- Maps kseg0/kseg1 virtual addresses to physical addresses.
- Each CPU request is accepted with an addr_ok pulse and completed with a data_ok pulse, so the core can stall on slow memory.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/sram_paddr_map.sv | 21 ++
 rtl/sram_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_mem_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side types: bus word/strobe types plus the memory arbiter's state and owner encodings.
package cpu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  strb_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic [1:0] {NONE, INST, DATA} arb_owner_t;

endpackage

// File: rtl/sram_paddr_map.sv
// Virtual-to-physical address translation for unmapped segments (kseg0/kseg1 fold onto low memory).
module sram_paddr_map #(
    parameter bit MAP_KSEG = 1'b1,
    parameter int ADDR_W   = 32
) (
    input  logic [ADDR_W-1:0] vaddr,
    output logic [ADDR_W-1:0] paddr
);

    logic [3:0] seg;

    // Segments 0x8..0xB are kseg0/kseg1; only bit 0 of the nibble survives.
    always_comb begin
        seg   = vaddr[ADDR_W-1 -: 4];
        paddr = vaddr;
        if (MAP_KSEG && (seg[3:2] == 2'b10)) begin
            paddr[ADDR_W-1 -: 4] = {3'b000, seg[0]};
        end
    end

endmodule

// File: rtl/sram_mem_arbiter.sv
// Arbitrates the CPU instruction and data SRAM-like ports onto one single-outstanding memory bus.
// Data has priority; each request is acknowledged with addr_ok and completed with data_ok.
module sram_mem_arbiter
    import cpu_pkg::*;
#(
    parameter bit MAP_KSEG = 1'b1,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t         state_q, state_d;
    arb_owner_t         owner_q, owner_d;
    logic               wr_q, wr_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;
    logic [ADDR_W-1:0]  grant_vaddr;
    logic [ADDR_W-1:0]  grant_paddr;

    assign grant_vaddr = data_req ? data_addr : inst_addr;

    sram_paddr_map #(
        .MAP_KSEG (MAP_KSEG),
        .ADDR_W   (ADDR_W)
    ) u_paddr_map (
        .vaddr (grant_vaddr),
        .paddr (grant_paddr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= NONE;
            wr_q         <= 1'b0;
            wstrb_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // addr_ok is gated by resetn so every output reads 0 while reset is held.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        wstrb_d      = wstrb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        mem_req      = 1'b0;

        case (state_q)
            IDLE: begin
                if (resetn && data_req) begin
                    data_addr_ok = 1'b1;
                    owner_d      = DATA;
                    wr_d         = data_wr;
                    wstrb_d      = data_wstrb;
                    addr_d       = grant_paddr;
                    wdata_d      = data_wdata;
                    state_d      = ISSUE;
                end else if (resetn && inst_req) begin
                    inst_addr_ok = 1'b1;
                    owner_d      = INST;
                    wr_d         = 1'b0;
                    wstrb_d      = '0;
                    addr_d       = grant_paddr;
                    wdata_d      = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (owner_q == INST) begin
                        inst_rdata_d = mem_rdata;
                    end else if (!wr_q) begin
                        data_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                inst_data_ok = (owner_q == INST);
                data_data_ok = (owner_q == DATA);
                owner_d      = NONE;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    assign mem_wr     = wr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Scoreboard bench for sram_mem_arbiter: one instance with kseg mapping, one without, selected by sel.
// A behavioural memory answers the bus; expected bus requests and completions are queued at grant time.
module tb_sram_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } memreq_t;

    typedef struct packed {
        logic        isData;
        logic        isWrite;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        sel;
    logic        inst_req, data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic inst_req_m, data_req_m, inst_req_n, data_req_n;
    assign inst_req_m = inst_req & ~sel;
    assign data_req_m = data_req & ~sel;
    assign inst_req_n = inst_req & sel;
    assign data_req_n = data_req & sel;

    logic        m_inst_addr_ok, m_inst_data_ok, m_data_addr_ok, m_data_data_ok, m_mem_req, m_mem_wr;
    logic [31:0] m_inst_rdata, m_data_rdata, m_mem_addr, m_mem_wdata;
    logic [3:0]  m_mem_wstrb;
    logic        n_inst_addr_ok, n_inst_data_ok, n_data_addr_ok, n_data_data_ok, n_mem_req, n_mem_wr;
    logic [31:0] n_inst_rdata, n_data_rdata, n_mem_addr, n_mem_wdata;
    logic [3:0]  n_mem_wstrb;

    sram_mem_arbiter #(.MAP_KSEG(1'b1), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req_m), .inst_addr(inst_addr),
        .inst_addr_ok(m_inst_addr_ok), .inst_data_ok(m_inst_data_ok), .inst_rdata(m_inst_rdata),
        .data_req(data_req_m), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(m_data_addr_ok), .data_data_ok(m_data_data_ok), .data_rdata(m_data_rdata),
        .mem_req(m_mem_req), .mem_wr(m_mem_wr), .mem_wstrb(m_mem_wstrb),
        .mem_addr(m_mem_addr), .mem_wdata(m_mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    sram_mem_arbiter #(.MAP_KSEG(1'b0), .ADDR_W(32), .DATA_W(32)) dutNoMap (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req_n), .inst_addr(inst_addr),
        .inst_addr_ok(n_inst_addr_ok), .inst_data_ok(n_inst_data_ok), .inst_rdata(n_inst_rdata),
        .data_req(data_req_n), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(n_data_addr_ok), .data_data_ok(n_data_data_ok), .data_rdata(n_data_rdata),
        .mem_req(n_mem_req), .mem_wr(n_mem_wr), .mem_wstrb(n_mem_wstrb),
        .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Observed view of whichever instance is currently selected
    logic        instAddrOk, instDataOk, dataAddrOk, dataDataOk, mReq, mWr;
    logic [31:0] instRdata, dataRdata, mAddr, mWdata;
    logic [3:0]  mWstrb;
    assign instAddrOk = sel ? n_inst_addr_ok : m_inst_addr_ok;
    assign instDataOk = sel ? n_inst_data_ok : m_inst_data_ok;
    assign dataAddrOk = sel ? n_data_addr_ok : m_data_addr_ok;
    assign dataDataOk = sel ? n_data_data_ok : m_data_data_ok;
    assign mReq       = sel ? n_mem_req      : m_mem_req;
    assign mWr        = sel ? n_mem_wr       : m_mem_wr;
    assign mWstrb     = sel ? n_mem_wstrb    : m_mem_wstrb;
    assign mAddr      = sel ? n_mem_addr     : m_mem_addr;
    assign mWdata     = sel ? n_mem_wdata    : m_mem_wdata;
    assign instRdata  = sel ? n_inst_rdata   : m_inst_rdata;
    assign dataRdata  = sel ? n_data_rdata   : m_data_rdata;

    int          totalChecks = 0;
    int          badChecks   = 0;
    int          cycle       = 0;
    int          doneCount   = 0;
    memreq_t     memQ[$];
    resp_t       respQ[$];
    logic [31:0] memWords [bit [31:0]];
    logic [31:0] lastInst [2];
    logic [31:0] lastData [2];
    int          readyWait   = 0;
    int          rvalidDelay = 0;
    int          respWait    = 0;
    bit          pendingResp = 1'b0;
    logic [31:0] respData    = '0;

    // Every comparison in the bench goes through here so the counts stay honest
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference address translation: kseg0/kseg1 fold to the low 512 MB
    function automatic logic [31:0] mapAddr(input logic [31:0] va, input bit en);
        logic [3:0] top;
        top = va[31:28];
        if (en && (top == 4'h8 || top == 4'hA)) return {4'h0, va[27:0]};
        if (en && (top == 4'h9 || top == 4'hB)) return {4'h1, va[27:0]};
        return va;
    endfunction

    function automatic logic [31:0] readWord(input logic [31:0] pa);
        if (memWords.exists(pa)) return memWords[pa];
        return pa ^ 32'h5A5A_C3C3;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // Behavioural memory: checks each bus request against the queue, then answers after programmed delays
    initial begin
        memreq_t     m;
        logic [31:0] w;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (pendingResp) begin
                if (resetn) checkOutput("mem_req_low_in_wait", mReq, 1'b0);
                if (respWait == 0) begin
                    mem_rvalid  = 1'b1;
                    mem_rdata   = respData;
                    pendingResp = 1'b0;
                end else begin
                    respWait--;
                end
            end else if (mReq) begin
                checkOutput("mem_req_expected", mReq, memQ.size() != 0);
                checkOutput("addr_ok_while_busy", {instAddrOk, dataAddrOk}, 2'b00);
                if (memQ.size() != 0) begin
                    m = memQ[0];
                    checkOutput("mem_addr", mAddr, m.addr);
                    checkOutput("mem_wr", mWr, m.wr);
                    checkOutput("mem_wstrb", mWstrb, m.wstrb);
                    if (m.wr) checkOutput("mem_wdata", mWdata, m.wdata);
                    if (readyWait == 0) begin
                        mem_ready = 1'b1;
                        void'(memQ.pop_front());
                        if (m.wr) begin
                            w = readWord(m.addr);
                            for (int b = 0; b < 4; b++) begin
                                if (m.wstrb[b]) w[8*b +: 8] = m.wdata[8*b +: 8];
                            end
                            memWords[m.addr] = w;
                            respData = 32'h0BAD_0BAD;
                        end else begin
                            respData = readWord(mAddr);
                        end
                        pendingResp = 1'b1;
                        respWait    = rvalidDelay;
                    end else begin
                        readyWait--;
                    end
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every data_ok pulse
    initial begin
        resp_t r;
        int    idx;
        forever begin
            @(negedge clk);
            idx = sel ? 1 : 0;
            if (instDataOk || dataDataOk) begin
                if (respQ.size() == 0) begin
                    checkOutput("unexpected_data_ok", {instDataOk, dataDataOk}, 2'b00);
                end else begin
                    r = respQ.pop_front();
                    checkOutput("data_ok_port", {instDataOk, dataDataOk}, r.isData ? 2'b01 : 2'b10);
                    if (r.isData) begin
                        checkOutput("data_rdata", dataRdata, r.rdata);
                        checkOutput("inst_rdata_hold", instRdata, lastInst[idx]);
                    end else begin
                        checkOutput("inst_rdata", instRdata, r.rdata);
                        checkOutput("data_rdata_hold", dataRdata, lastData[idx]);
                    end
                    doneCount++;
                end
            end
        end
    end

    task automatic waitDone(input int startDone, input int grantCycle, output int latency);
        int n;
        n = 0;
        while (doneCount == startDone && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("completion_seen", doneCount != startDone, 1'b1);
        latency = cycle - grantCycle;
    endtask

    task automatic pushExpect(input bit isData, input bit wr, input logic [3:0] wstrb,
                              input logic [31:0] pa, input logic [31:0] wd);
        memreq_t m;
        resp_t   r;
        int      idx;
        idx     = sel ? 1 : 0;
        m.addr  = pa;
        m.wr    = isData && wr;
        m.wstrb = isData ? wstrb : 4'h0;
        m.wdata = wd;
        memQ.push_back(m);
        r.isData  = isData;
        r.isWrite = isData && wr;
        r.rdata   = r.isWrite ? lastData[idx] : readWord(pa);
        if (!r.isWrite) begin
            if (isData) lastData[idx] = r.rdata;
            else        lastInst[idx] = r.rdata;
        end
        respQ.push_back(r);
    endtask

    // One complete CPU transaction on one port; reports grant wait and addr_ok-to-data_ok latency
    task automatic applyStimulus(input bit isData, input bit wr, input logic [3:0] wstrb,
                                 input logic [31:0] va, input logic [31:0] wd,
                                 output int grantWait, output int latency);
        logic [31:0] pa;
        int          startDone, grantCycle;
        logic        ok, otherOk;
        pa = mapAddr(va, !sel);
        @(negedge clk);
        if (isData) begin
            data_req = 1'b1; data_wr = wr; data_wstrb = wstrb; data_addr = va; data_wdata = wd;
        end else begin
            inst_req = 1'b1; inst_addr = va;
        end
        grantWait = 0;
        #1;
        ok = isData ? dataAddrOk : instAddrOk;
        while (!ok && grantWait < 40) begin
            @(negedge clk);
            #1;
            grantWait++;
            ok = isData ? dataAddrOk : instAddrOk;
        end
        otherOk = isData ? instAddrOk : dataAddrOk;
        checkOutput("addr_ok_seen", ok, 1'b1);
        checkOutput("addr_ok_other_low", otherOk, 1'b0);
        latency = -1;
        if (ok) begin
            pushExpect(isData, wr, wstrb, pa, wd);
            startDone  = doneCount;
            grantCycle = cycle;
            @(negedge clk);
            inst_req = 1'b0; data_req = 1'b0;
            waitDone(startDone, grantCycle, latency);
        end else begin
            inst_req = 1'b0; data_req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int gw, lat, n, startDone, grantCycle;
        logic [31:0] a, keepRd;
        logic [31:0] segs [4];

        resetn = 1'b0; sel = 1'b0;
        inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0;
        inst_addr = '0; data_addr = '0; data_wdata = '0;
        for (int i = 0; i < 2; i++) begin lastInst[i] = '0; lastData[i] = '0; end
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl_outputs",
                    {instAddrOk, instDataOk, dataAddrOk, dataDataOk, mReq, mWr, mWstrb}, '0);
        checkOutput("reset_mem_addr", mAddr, '0);
        checkOutput("reset_rdata", {instRdata, dataRdata}, '0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] data read through kseg1");
        memWords[32'h1FC0_0100] = 32'h1234_5678;
        applyStimulus(1'b1, 1'b0, 4'h0, 32'hBFC0_0100, 32'h0, gw, lat);
        checkOutput("t1_grant_wait", gw, 0);
        checkOutput("t1_latency", lat, 3);
        checkOutput("t1_data_rdata", dataRdata, 32'h1234_5678);

        $display("[TB] simultaneous inst and data, data wins");
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
        data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("t2_data_wins", {dataAddrOk, instAddrOk}, 2'b10);
        pushExpect(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        startDone = doneCount;
        @(negedge clk);
        data_req = 1'b0;
        n = 0;
        while (doneCount == startDone && n < 40) begin
            #1;
            checkOutput("t2_inst_blocked", instAddrOk, 1'b0);
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("t2_data_done", doneCount != startDone, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("t2_inst_granted", instAddrOk, 1'b1);
        pushExpect(1'b0, 1'b0, 4'h0, 32'h1FC0_0000, 32'h0);
        startDone = doneCount; grantCycle = cycle;
        @(negedge clk);
        inst_req = 1'b0;
        waitDone(startDone, grantCycle, lat);
        checkOutput("t2_inst_latency", lat, 3);

        $display("[TB] memory stalls mem_ready for 5 cycles");
        readyWait = 5;
        applyStimulus(1'b1, 1'b1, 4'hC, 32'hA000_0200, 32'hCAFE_F00D, gw, lat);
        checkOutput("t3_latency", lat, 8);
        readyWait = 5;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h8000_0200, 32'h0, gw, lat);
        checkOutput("t3_read_latency", lat, 8);

        $display("[TB] reset dropped while waiting for the response");
        rvalidDelay = 4;
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h9000_0040;
        #1;
        checkOutput("t4_addr_ok", instAddrOk, 1'b1);
        pushExpect(1'b0, 1'b0, 4'h0, 32'h1000_0040, 32'h0);
        @(negedge clk);
        inst_req = 1'b0;
        n = 0;
        while (!pendingResp && n < 20) begin @(negedge clk); #1; n++; end
        checkOutput("t4_in_wait", pendingResp, 1'b1);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        respQ.delete();
        memQ.delete();
        for (int i = 0; i < 2; i++) begin lastInst[i] = '0; lastData[i] = '0; end
        #1;
        checkOutput("t4_ctrl_zero",
                    {instAddrOk, instDataOk, dataAddrOk, dataDataOk, mReq, mWr, mWstrb}, '0);
        checkOutput("t4_mem_addr_zero", mAddr, '0);
        checkOutput("t4_mem_wdata_zero", mWdata, '0);
        checkOutput("t4_rdata_zero", {instRdata, dataRdata}, '0);
        rvalidDelay = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("t4_stray_rvalid_sent", pendingResp, 1'b0);
        checkOutput("t4_inst_rdata_after_stray", instRdata, '0);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'hBFC0_0004, 32'h0, gw, lat);
        checkOutput("t4_after_reset_latency", lat, 3);

        $display("[TB] instance without kseg mapping");
        @(negedge clk);
        sel = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h0, 32'hA000_0004, 32'h0, gw, lat);
        keepRd = mapAddr(32'hA000_0004, 1'b0) ^ 32'h5A5A_C3C3;
        checkOutput("t5_read_unmapped", dataRdata, keepRd);
        applyStimulus(1'b1, 1'b1, 4'h2, 32'hA000_0004, 32'h1122_AB44, gw, lat);
        checkOutput("t5_rdata_kept_after_write", dataRdata, keepRd);
        applyStimulus(1'b1, 1'b0, 4'h0, 32'hA000_0004, 32'h0, gw, lat);
        checkOutput("t5_byte_merged", dataRdata, {keepRd[31:16], 8'hAB, keepRd[7:0]});
        @(negedge clk);
        sel = 1'b0;

        $display("[TB] mixed traffic with random bus delays");
        segs[0] = 32'h8000_0300; segs[1] = 32'hB000_0300; segs[2] = 32'h0040_0300; segs[3] = 32'hC000_0300;
        for (int i = 0; i < 16; i++) begin
            a           = segs[$urandom_range(3)] + {28'h0, 2'($urandom_range(3)), 2'b00};
            readyWait   = $urandom_range(3);
            rvalidDelay = $urandom_range(3);
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)),
                          a, $urandom, gw, lat);
        end
        rvalidDelay = 0;
        repeat (4) @(negedge clk);
        checkOutput("final_queues_empty", memQ.size() + respQ.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
